// File: rtl/cam_capture.sv
// DVP camera input stage: registers VSYNC/HREF/DATA, pairs bytes into RGB565
// pixels and writes them to the camera FIFO, framed to whole frames.
module cam_capture #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned VSYNC_POL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        clr_err,
  input  logic        wrfull,
  output logic        wrreq,
  output logic [15:0] wrdata,
  output logic        capturing,
  output logic        frame_start,
  output logic        frame_done,
  output logic        overflow,
  output logic        geom_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          vs_r_q, vs_r_d, hr_r_q, hr_r_d;
  logic [DW-1:0] d_r_q, d_r_d;
  logic          vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic          byte_phase_q, byte_phase_d;
  logic [DW-1:0] hi_byte_q, hi_byte_d;
  logic          wrreq_q, wrreq_d;
  logic [PW-1:0] wrdata_q, wrdata_d;
  logic          capturing_q, capturing_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic          geom_err_q, geom_err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic vs_act, vs_rise, vs_fall, hr_fall;
  logic ovf_evt, geom_evt;

  // vsync asserted (blanking) according to the configured polarity
  assign vs_act  = vs_r_q ~^ 1'(VSYNC_POL);
  assign vs_rise = vs_act & ~vs_prev_q;
  assign vs_fall = ~vs_act & vs_prev_q;
  assign hr_fall = ~hr_r_q & hr_prev_q;

  always_comb begin
    vs_r_d        = cam_vsync;
    hr_r_d        = cam_href;
    d_r_d         = cam_data;
    vs_prev_d     = vs_act;
    hr_prev_d     = hr_r_q;
    state_d       = state_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    byte_phase_d  = byte_phase_q;
    hi_byte_d     = hi_byte_q;
    wrreq_d       = 1'b0;
    wrdata_d      = wrdata_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    ovf_evt       = 1'b0;
    geom_evt      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        x_cnt_d      = '0;
        y_cnt_d      = '0;
        byte_phase_d = 1'b0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (vs_fall) begin
          state_d       = S_CAPTURE;
          frame_start_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        // bytes seen during vertical blanking are a protocol error, never written
        if (hr_r_q && vs_act) begin
          geom_evt = 1'b1;
        end else if (hr_r_q) begin
          byte_phase_d = ~byte_phase_q;
          if (!byte_phase_q) begin
            hi_byte_d = d_r_q;
          end else begin
            x_cnt_d = (x_cnt_q == {XW{1'b1}}) ? x_cnt_q : x_cnt_q + XW'(1);
            if (wrfull) begin
              ovf_evt = 1'b1;
            end else begin
              wrreq_d  = 1'b1;
              wrdata_d = {hi_byte_q, d_r_q};
            end
          end
        end
        if (hr_fall) begin
          if ((x_cnt_q != XW'(H_ACTIVE)) || byte_phase_q) geom_evt = 1'b1;
          y_cnt_d      = (y_cnt_q == {YW{1'b1}}) ? y_cnt_q : y_cnt_q + YW'(1);
          x_cnt_d      = '0;
          byte_phase_d = 1'b0;
        end
        // end of frame: a started frame always completes regardless of enable
        if (vs_rise) begin
          if (y_cnt_q != YW'(V_ACTIVE)) geom_evt = 1'b1;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          state_d      = enable ? S_WAIT_VS : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a new error event wins over a coincident clear
    overflow_d  = ovf_evt | (overflow_q & ~clr_err);
    geom_err_d  = geom_evt | (geom_err_q & ~clr_err);
    capturing_d = (state_d == S_CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      vs_r_q        <= 1'b0;
      hr_r_q        <= 1'b0;
      d_r_q         <= '0;
      vs_prev_q     <= 1'b0;
      hr_prev_q     <= 1'b0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      byte_phase_q  <= 1'b0;
      hi_byte_q     <= '0;
      wrreq_q       <= 1'b0;
      wrdata_q      <= '0;
      capturing_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      geom_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      vs_r_q        <= vs_r_d;
      hr_r_q        <= hr_r_d;
      d_r_q         <= d_r_d;
      vs_prev_q     <= vs_prev_d;
      hr_prev_q     <= hr_prev_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      byte_phase_q  <= byte_phase_d;
      hi_byte_q     <= hi_byte_d;
      wrreq_q       <= wrreq_d;
      wrdata_q      <= wrdata_d;
      capturing_q   <= capturing_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      geom_err_q    <= geom_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign wrreq       = wrreq_q;
  assign wrdata      = wrdata_q;
  assign capturing   = capturing_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign geom_err    = geom_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: table of frame scenarios plus random frames, checked
// against a byte-level model of pixel pairing, FIFO drops and frame geometry.
module tb_cam_capture;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned LB = 2 * H;

  logic        clk = 1'b0;
  logic        reset, enable, cam_vsync, cam_href, clr_err, wrfull;
  logic [7:0]  cam_data;
  logic        wrreq, capturing, frame_start, frame_done, overflow, geom_err;
  logic [15:0] wrdata, frame_cnt;

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .clr_err(clr_err), .wrfull(wrfull),
    .wrreq(wrreq), .wrdata(wrdata), .capturing(capturing), .frame_start(frame_start),
    .frame_done(frame_done), .overflow(overflow), .geom_err(geom_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; int cyc; } pix_t;
  // mode: 0 enabled, 1 enable raised mid-frame, 2 enable dropped mid-frame, 3 disabled
  typedef struct { int lines; int bad_line; int bad_bytes; int pct; bit hv; int mode; bit exp_geom; } vec_t;

  int   checks = 0, failures = 0, cyc = 0;
  pix_t exp_q[$];
  pix_t pend_pix, mon_e;
  bit   pend = 0, active = 0, exp_ovf = 0, mon_en = 0, rst_prev = 0, due;
  int   exp_frames = 0, exp_starts = 0, exp_dones = 0, n_starts = 0, n_dones = 0, bidx = 0;
  logic [7:0]  prev_byte = '0;
  logic [15:0] last_data = '0;
  vec_t vecs[14];
  vec_t rv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pixel stream checker: a pixel whose second byte was driven in cycle c
  // must appear on wrreq exactly two cycles later.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_prev) last_data = 16'h0;
      if (frame_start) n_starts++;
      if (frame_done) n_dones++;
      due = (exp_q.size() != 0) && (exp_q[0].cyc + 2 == cyc);
      chk("wrreq", 32'(wrreq), 32'(due));
      if (due) begin
        mon_e = exp_q.pop_front();
        if (wrreq) begin
          chk("wrdata", 32'(wrdata), 32'(mon_e.data));
          last_data = mon_e.data;
        end
      end else if (!wrreq) begin
        chk("wrdata_hold", 32'(wrdata), 32'(last_data));
      end
      rst_prev = !reset;
    end
  end

  // One camera clock of stimulus plus the model update for it.
  task automatic step(input logic vs, input logic hr, input int pct, input logic clr, input logic rst);
    logic [7:0] d;
    @(posedge clk);
    #1;
    wrfull = (int'($urandom_range(99)) < pct);
    if (clr) exp_ovf = 1'b0;
    if (rst) begin
      active = 0; exp_ovf = 0; exp_frames = 0; pend = 0;
    end
    if (pend) begin
      pend = 0;
      if (wrfull) exp_ovf = 1'b1;
      else exp_q.push_back(pend_pix);
    end
    d = 8'($urandom_range(255));
    cam_vsync = vs; cam_href = hr; cam_data = d; clr_err = clr; reset = ~rst;
    if (!hr) begin
      bidx = 0;
    end else if (!vs) begin
      if (active && (bidx % 2 == 1)) begin
        pend = 1;
        pend_pix.data = {prev_byte, d};
        pend_pix.cyc = cyc;
      end
      prev_byte = d;
      bidx++;
    end
  endtask

  task automatic run_frame(input vec_t v);
    int nb;
    enable = (v.mode == 0 || v.mode == 2);
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, v.pct, 0, 0);
    active = enable;
    if (active) exp_starts++;
    repeat (2) step(0, 0, v.pct, 0, 0);
    for (int l = 0; l < v.lines; l++) begin
      nb = (l == v.bad_line) ? v.bad_bytes : int'(LB);
      if (v.mode == 2 && l == 1) enable = 1'b0;
      for (int b = 0; b < nb; b++) begin
        if (v.mode == 1 && l == 1 && b == 5) enable = 1'b1;
        step(0, 1, v.pct, 0, 0);
      end
      repeat (3) step(0, 0, v.pct, 0, 0);
    end
    step(1, v.hv, v.pct, 0, 0);
    if (active) begin
      exp_frames++; exp_dones++; active = 0;
    end
    repeat (4) step(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("geom_err", 32'(geom_err), 32'(v.exp_geom));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames[15:0]));
    chk("pixels_left", 32'(exp_q.size()), 0);
    chk("frame_starts", 32'(n_starts), 32'(exp_starts));
    chk("frame_dones", 32'(n_dones), 32'(exp_dones));
    chk("capturing_after", 32'(capturing), 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("overflow_clr", 32'(overflow), 0);
    chk("geom_clr", 32'(geom_err), 0);
  endtask

  initial begin
    reset = 0; enable = 0; cam_vsync = 0; cam_href = 0; cam_data = '0; clr_err = 0; wrfull = 0;
    vecs[0]  = '{int'(V),     -1, 0,            0,  0, 0, 1'b0};
    vecs[1]  = '{int'(V),     -1, 0,            40, 0, 0, 1'b0};
    vecs[2]  = '{int'(V),      1, int'(LB) - 2, 20, 0, 0, 1'b1};
    vecs[3]  = '{int'(V) - 1, -1, 0,            0,  0, 0, 1'b1};
    vecs[4]  = '{int'(V) + 1, -1, 0,            0,  0, 0, 1'b1};
    vecs[5]  = '{int'(V),      0, int'(LB) - 1, 0,  0, 0, 1'b1};
    vecs[6]  = '{int'(V),      2, int'(LB) + 1, 0,  0, 0, 1'b1};
    vecs[7]  = '{int'(V),      3, int'(LB) + 2, 10, 0, 0, 1'b1};
    vecs[8]  = '{int'(V),     -1, 0,            0,  1, 0, 1'b1};
    vecs[9]  = '{int'(V),     -1, 0,            0,  0, 1, 1'b0};
    vecs[10] = '{int'(V),     -1, 0,            30, 0, 0, 1'b0};
    vecs[11] = '{int'(V),     -1, 0,            0,  0, 2, 1'b0};
    vecs[12] = '{int'(V),     -1, 0,            0,  0, 3, 1'b0};
    vecs[13] = '{int'(V),     -1, 0,            50, 0, 0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wrreq", 32'(wrreq), 0);
    chk("rst_wrdata", 32'(wrdata), 0);
    chk("rst_capturing", 32'(capturing), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_geom_err", 32'(geom_err), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    step(1, 0, 0, 0, 0);
    mon_en = 1;

    for (int i = 0; i < 14; i++) run_frame(vecs[i]);

    for (int i = 0; i < 8; i++) begin
      int sel;
      rv.lines    = int'(V) - 1 + int'($urandom_range(2));
      rv.bad_line = int'($urandom_range(V + 1));
      sel         = int'($urandom_range(4));
      rv.bad_bytes = (sel == 0) ? int'(LB) - 2 : (sel == 1) ? int'(LB) - 1 :
                     (sel == 2) ? int'(LB) + 1 : int'(LB);
      rv.pct      = int'($urandom_range(60));
      rv.hv       = ($urandom_range(3) == 0);
      rv.mode     = 0;
      rv.exp_geom = (rv.lines != int'(V)) || rv.hv ||
                    ((rv.bad_line < rv.lines) && (rv.bad_bytes != int'(LB)));
      run_frame(rv);
    end

    // reset in the middle of a line
    enable = 1;
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    active = 1; exp_starts++;
    repeat (2) step(0, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++) step(0, 1, 100, 0, 0);
    @(negedge clk);
    chk("ovf_before_reset", 32'(overflow), 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst_wrreq", 32'(wrreq), 0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_geom", 32'(geom_err), 0);
    chk("mid_rst_capturing", 32'(capturing), 0);
    for (int b = 6; b < int'(LB); b++) step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    for (int b = 0; b < int'(LB); b++) step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_dones", 32'(n_dones), 32'(exp_dones));
    chk("post_rst_frame_cnt", 32'(frame_cnt), 0);
    run_frame(vecs[0]);

    repeat (3) step(1, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
